// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C transaction arbiter: FSM encoding and index width.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Width of the round-robin pointer and winner index; covers up to 8 requesters.
    localparam int IDX_W = 3;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    always_comb begin
        int i;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        i     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (int'(ptr_i) + k) % NUM_REQ;
            if (!vld_o && req_i[i]) begin
                vld_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters; latches the
// winner's fields, drives start, and reports done or start-timeout err.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_LEN = 7,
    parameter int DATA_LEN = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_1,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_2,
    output logic [NUM_REQ-1:0]           gnt,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err,
    output logic                         m_start,
    output logic [ADDR_LEN-1:0]          m_add_reg,
    output logic                         m_R_W,
    output logic [DATA_LEN-1:0]          m_data_1,
    output logic [DATA_LEN-1:0]          m_data_2,
    input  logic                         m_free
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic                 start_q, start_d, rw_q, rw_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [DATA_LEN-1:0]  d1_q, d1_d, d2_q, d2_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, idx_q, idx_d, ptr_next;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // After a transaction the owner moves to the back of the priority order.
    assign ptr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        start_d = start_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (m_free && pick_vld) begin
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    addr_d  = req_addr[pick_idx*ADDR_LEN +: ADDR_LEN];
                    rw_d    = req_rw[pick_idx];
                    d1_d    = req_data_1[pick_idx*DATA_LEN +: DATA_LEN];
                    d2_d    = req_data_2[pick_idx*DATA_LEN +: DATA_LEN];
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d = cnt_q + 1'b1;
                // Master accepting the start wins over a timeout in the same cycle.
                if (!m_free) begin
                    start_d = 1'b0;
                    state_d = RUN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    start_d = 1'b0;
                    gnt_d   = '0;
                    err_d   = gnt_q;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (m_free) begin
                    done_d  = gnt_q;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                gnt_d   = '0;
                ptr_d   = ptr_next;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            d1_q    <= '0;
            d2_q    <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign m_start   = start_q;
    assign m_add_reg = addr_q;
    assign m_R_W     = rw_q;
    assign m_data_1  = d1_q;
    assign m_data_2  = d2_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed scoreboard bench for i2c_txn_arbiter (4 requesters, TIMEOUT=8).
module tb_i2c_txn_arbiter;

    localparam int N  = 4;
    localparam int AL = 7;
    localparam int DL = 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*AL-1:0]   req_addr;
    logic [N-1:0]      req_rw;
    logic [N*DL-1:0]   req_data_1, req_data_2;
    logic [N-1:0]      gnt, done, err;
    logic              m_start, m_R_W, m_free;
    logic [AL-1:0]     m_add_reg;
    logic [DL-1:0]     m_data_1, m_data_2;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int           idx;
        logic [AL-1:0] addr;
        logic          rw;
        logic [DL-1:0] d1;
        logic [DL-1:0] d2;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    i2c_txn_arbiter #(.NUM_REQ(N), .ADDR_LEN(AL), .DATA_LEN(DL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_data_1(req_data_1), .req_data_2(req_data_2), .gnt(gnt), .done(done),
        .err(err), .m_start(m_start), .m_add_reg(m_add_reg), .m_R_W(m_R_W),
        .m_data_1(m_data_1), .m_data_2(m_data_2), .m_free(m_free)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic [AL-1:0] a, input logic rw,
                              input logic [DL-1:0] d1, input logic [DL-1:0] d2);
        req_addr[i*AL +: AL]   = a;
        req_rw[i]              = rw;
        req_data_1[i*DL +: DL] = d1;
        req_data_2[i*DL +: DL] = d2;
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.idx  = i;
        e.addr = req_addr[i*AL +: AL];
        e.rw   = req_rw[i];
        e.d1   = req_data_1[i*DL +: DL];
        e.d2   = req_data_2[i*DL +: DL];
        sb.push_back(e);
    endtask

    // Wait at most 'budget' cycles for a grant, then compare it against the scoreboard head.
    task automatic expect_grant(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("grant_seen", 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        cur = sb.pop_front();
        chk("gnt",       32'(gnt),       32'(onehot(cur.idx)));
        chk("m_start",   32'(m_start),   32'd1);
        chk("m_add_reg", 32'(m_add_reg), 32'(cur.addr));
        chk("m_R_W",     32'(m_R_W),     32'(cur.rw));
        chk("m_data_1",  32'(m_data_1),  32'(cur.d1));
        chk("m_data_2",  32'(m_data_2),  32'(cur.d2));
    endtask

    // Master accepts the start after n cycles by pulling m_free low.
    task automatic launch(input int n);
        for (int k = 0; k < n; k++) begin
            chk("start_hi", 32'(m_start), 32'd1);
            if (k == n - 1) m_free = 1'b0;
            @(negedge clk);
        end
        chk("start_lo", 32'(m_start), 32'd0);
        chk("gnt_run",  32'(gnt),     32'(onehot(cur.idx)));
    endtask

    // Master stays busy, then goes idle; expect a one-cycle done and grant release.
    task automatic finish(input int busy, input bit drop_at_done);
        repeat (busy - 1) @(negedge clk);
        chk("addr_frozen", 32'(m_add_reg), 32'(cur.addr));
        m_free = 1'b1;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(onehot(cur.idx)));
        chk("err_quiet",  32'(err),  32'd0);
        chk("gnt_finish", 32'(gnt),  32'(onehot(cur.idx)));
        if (drop_at_done) req = '0;
        @(negedge clk);
        chk("done_clr", 32'(done), 32'd0);
        chk("gnt_clr",  32'(gnt),  32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        req_addr   = '0;
        req_rw     = '0;
        req_data_1 = '0;
        req_data_2 = '0;
        m_free     = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_start", 32'(m_start),   32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_addr",  32'(m_add_reg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // Single request from requester 1
        set_fields(1, 7'h50, 1'b0, 8'hA5, 8'h3C);
        req = 4'b0010;
        push_exp(1);
        expect_grant(1);
        launch(3);
        finish(40, 1'b1);

        // Busy master blocks arbitration
        m_free = 1'b0;
        set_fields(0, 7'h2A, 1'b1, 8'h01, 8'h02);
        req = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("busy_gnt",   32'(gnt),     32'd0);
            chk("busy_start", 32'(m_start), 32'd0);
        end
        m_free = 1'b1;
        push_exp(0);
        expect_grant(1);
        launch(2);
        finish(5, 1'b1);

        // Start timeout: pointer is 1, requesters 1 and 2 compete
        set_fields(1, 7'h33, 1'b1, 8'h44, 8'h55);
        set_fields(2, 7'h66, 1'b0, 8'h77, 8'h88);
        req = 4'b0110;
        push_exp(1);
        push_exp(2);
        expect_grant(1);
        for (int k = 0; k < TO; k++) begin
            chk("to_start_hi", 32'(m_start), 32'd1);
            chk("to_err_quiet", 32'(err), 32'd0);
            @(negedge clk);
        end
        chk("to_err",   32'(err),     32'(onehot(1)));
        chk("to_done",  32'(done),    32'd0);
        chk("to_gnt",   32'(gnt),     32'd0);
        chk("to_start", 32'(m_start), 32'd0);
        req = 4'b0100;
        expect_grant(1);
        chk("to_err_clr", 32'(err), 32'd0);
        launch(2);

        // Asynchronous reset while RUN
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt",   32'(gnt),       32'd0);
        chk("arst_start", 32'(m_start),   32'd0);
        chk("arst_done",  32'(done),      32'd0);
        chk("arst_err",   32'(err),       32'd0);
        chk("arst_addr",  32'(m_add_reg), 32'd0);
        req    = '0;
        m_free = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin with all four requesting; pointer restarts at 0
        for (int i = 0; i < N; i++)
            set_fields(i, 7'(8'h10 + i), i[0], 8'(8'hB0 + i), 8'(8'hC0 + i));
        req = 4'b1111;
        for (int i = 0; i < N; i++) push_exp(i);
        for (int t = 0; t < 5; t++) begin
            expect_grant(1);
            launch(1);
            if (t == 0) begin
                req_addr[0 +: AL] = 7'h11;
                push_exp(0);
            end
            finish(4, t == 4);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_regrant", 32'(gnt), 32'd0);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C master controller (start/add_reg/R_W/data_1/data_2 in, free out) among NUM_REQ requesters with round-robin fairness.
- Latches the winning requester's transaction fields and drives the master's start.
- Watches the master's free handshake and returns a one-cycle done, or err on timeout, to the owning requester.
- Sits between system-side clients and the I2C master top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_LEN, 7, slave address width
DATA_LEN, 8, data byte width
TIMEOUT, 1023, max clk cycles from start assertion to master free deasserting

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester transaction request (level)
req_addr  in  NUM_REQ*ADDR_LEN  packed addresses, requester i at [i*ADDR_LEN +: ADDR_LEN]
req_rw  in  NUM_REQ  per-requester R_W bit
req_data_1  in  NUM_REQ*DATA_LEN  packed first data bytes
req_data_2  in  NUM_REQ*DATA_LEN  packed second data bytes
gnt  out  NUM_REQ  one-hot owner of master, held for whole transaction
done  out  NUM_REQ  one-hot, 1-cycle pulse on successful completion
err  out  NUM_REQ  one-hot, 1-cycle pulse on start timeout
m_start  out  1  start to master
m_add_reg  out  ADDR_LEN  latched address to master
m_R_W  out  1  latched R_W to master
m_data_1  out  DATA_LEN  latched data_1 to master
m_data_2  out  DATA_LEN  latched data_2 to master
m_free  in  1  master idle indicator (1 = idle)

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous, active-low. Reset values: state IDLE, gnt/done/err/m_start 0, m_add_reg/m_R_W/m_data_1/m_data_2 0, rr pointer 0, timeout counter 0. All outputs are registered.
- Reset mid-transaction: immediate return to IDLE with m_start dropped. No done or err is issued. The master is reset by the same rst_n.
- States: IDLE, LAUNCH, RUN, FINISH.
- IDLE:
  - If m_free=1 and |req: select the first set req at or after the pointer (wrap modulo NUM_REQ).
  - Next edge: gnt=onehot(winner); latch that requester's addr/rw/data into m_* outputs; m_start=1; counter=0; go LAUNCH.
  - Latency: 1 cycle from req sampled to gnt/m_start.
  - If m_free=0, no grant is issued regardless of req.
- LAUNCH:
  - m_start held at 1; counter increments each cycle.
  - On m_free=0: m_start=0, go RUN.
  - On counter reaching TIMEOUT with m_free still 1: m_start=0, gnt=0, err[winner] pulse 1 cycle, pointer=winner+1 (wrap), go IDLE.
  - m_free=0 takes priority over timeout in the same cycle.
- RUN: m_* outputs stay frozen. On m_free=1, go FINISH.
- FINISH (exactly 1 cycle): done[winner]=1; gnt cleared on exit; pointer=winner+1 (wrap); go IDLE. Requests are not arbitrated in FINISH.
- Minimum spacing between grants: 1 IDLE cycle after FINISH/err.
- Requester rules:
  - req must be held until its done or err.
  - Fields are sampled only at grant, so later changes have no effect.
  - Deassertion of req after grant does not abort the transaction; done/err is still issued.
  - A requester dropping req in the cycle of done is not re-granted. If req remains high, it is re-queued behind others by the pointer.
- Simultaneous requests: strict round-robin from pointer. With pointer p, priority order is p, p+1, …, p-1.
- Invariants: gnt, done and err are each one-hot or zero. done and err are never both set.

Decomposition:
- Package i2c_arb_pkg: state encoding localparams (IDLE=2'd0, LAUNCH=2'd1, RUN=2'd2, FINISH=2'd3) and the log2 width of the pointer/index.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req and the pointer.
  - Outputs: one-hot winner, index, and valid.
  - Instantiated once.
- Top level holds the FSM, latches, timeout counter and pointer.

Test Plan:
- Single request: req=4'b0010, addr 7'h50, rw 0, data 8'hA5/8'h3C, m_free=1; master model drops free 3 cycles after start, raises after 40 -> gnt=4'b0010 next cycle, m_add_reg=7'h50, m_start high 3 cycles, done=4'b0010 for 1 cycle at FINISH, gnt back to 0.
- Round-robin: req=4'b1111 held, each transaction completes -> grant order 0,1,2,3,0; no requester granted twice in a row.
- Field stability: after grant change req_addr[0] to 7'h11 mid-transaction -> m_add_reg stays at latched value until done.
- Timeout: TIMEOUT=8, m_free held 1 -> m_start high exactly 8 cycles, err one-hot pulse, no done, next requester granted afterwards.
- Busy master: m_free=0 with req=4'b0001 for 20 cycles -> no gnt/m_start; grant 1 cycle after m_free rises.
- Async reset in RUN: assert rst_n=0 off-edge -> gnt, m_start, done, err all 0 immediately; after release IDLE with pointer 0.
